// File: rtl/rec_pkg.sv
// Shared constants, output-slot state encoding and index sizing helper for the
// PCM frame packer.
package rec_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int NWORDS_DEF = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Bits needed to hold indices 0..v-1 (minimum 1).
    function automatic int rec_log2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pcm_frame_packer_if.sv
// Valid/ready output slot carrying one packed PCM frame from the packer to its
// consumer.
interface pcm_frame_packer_if import rec_pkg::*; #(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NWORDS = NWORDS_DEF
) ();

    logic                     out_valid;
    logic                     out_ready;
    logic [DWIDTH*NWORDS-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/rise_edge_det.sv
// Registers a level input and flags the cycle in which it goes from 0 to 1.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= 1'b0;
        else        r_q <= i_sig;
    end

    assign o_rise = i_sig & ~r_q;

endmodule

// File: rtl/pcm_frame_packer.sv
// Packs NWORDS level-qualified samples into one frame and offers it on a
// registered valid/ready slot. Optional VAD gating via macro VAD_GATE_EN.
module pcm_frame_packer import rec_pkg::*; #(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NWORDS = NWORDS_DEF,
    parameter int FCNT_W = 16,
    parameter int OVF_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dv,
    input  logic signed [DWIDTH-1:0] dat_i,
    input  logic                     flush,
`ifdef VAD_GATE_EN
    input  logic                     vad,
`endif
    pcm_frame_packer_if.master       slot,
    output logic                     half_pulse,
    output logic [FCNT_W-1:0]        frame_cnt,
    output logic [OVF_W-1:0]         ovf_cnt
);

    localparam int IDX_W = rec_log2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(NWORDS / 2 - 1);

    logic                               w_dv_rise;
    logic                               w_cap;
    logic                               w_flush;
    logic                               w_commit;
    logic                               w_take;
    logic                               w_drop;
    logic [NWORDS-1:0][DWIDTH-1:0]      w_frame;
    slot_e                              w_state_nxt;

    slot_e                              r_state;
    logic [IDX_W-1:0]                   r_idx;
    logic [NWORDS-2:0][DWIDTH-1:0]      r_fill;
    logic [NWORDS-1:0][DWIDTH-1:0]      r_data;
    logic                               r_half;
    logic [FCNT_W-1:0]                  r_frame_cnt;
    logic [OVF_W-1:0]                   r_ovf;

    rise_edge_det u_dv_rise (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_sig  (dv),
        .o_rise (w_dv_rise)
    );

`ifdef VAD_GATE_EN
    logic w_vad_fall;

    // A rise of ~vad is a fall of vad; it discards a partial utterance frame.
    rise_edge_det u_vad_fall (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_sig  (~vad),
        .o_rise (w_vad_fall)
    );

    assign w_cap   = w_dv_rise & vad;
    assign w_flush = flush | (w_vad_fall & (r_idx != '0));
`else
    assign w_cap   = w_dv_rise;
    assign w_flush = flush;
`endif

    assign w_commit = w_cap & ~w_flush & (r_idx == LAST_IDX);
    assign w_take   = w_commit & ((r_state == SLOT_EMPTY) | slot.out_ready);
    assign w_drop   = w_commit & (r_state == SLOT_FULL) & ~slot.out_ready;

    // The final sample goes straight from dat_i into the committed frame.
    assign w_frame  = {dat_i, r_fill};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_fill      <= '0;
            r_data      <= '0;
            r_half      <= 1'b0;
            r_frame_cnt <= '0;
            r_ovf       <= '0;
        end else begin
            r_half <= w_cap & ~w_flush & (r_idx == HALF_IDX);
            if (w_flush) begin
                r_idx <= '0;
            end else if (w_cap) begin
                if (r_idx == LAST_IDX) begin
                    r_idx <= '0;
                end else begin
                    r_fill[r_idx] <= dat_i;
                    r_idx         <= r_idx + 1'b1;
                end
            end
            if (w_take) begin
                r_data      <= w_frame;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= SLOT_EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_commit) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (slot.out_ready && !w_commit) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    assign slot.out_valid = (r_state == SLOT_FULL);
    assign slot.out_data  = r_data;
    assign half_pulse     = r_half;
    assign frame_cnt      = r_frame_cnt;
    assign ovf_cnt        = r_ovf;

endmodule

// File: doc/pcm_frame_packer.md
Name: pcm_frame_packer

Overview:
- Generalised successor of the microphone sample recorder.
- Collects NWORDS signed DWIDTH-bit samples, each marked by a level-type data-valid from the mic decimator, into one packed frame.
- Presents the frame on a valid/ready output slot for downstream feature and DNN logic.
- Adds parametrised width and depth, a registered output slot, overflow accounting, a flush input, a half-frame strobe and a frame counter.

Parameters:
- DWIDTH, 16, bits per input sample.
- NWORDS, 16, samples per frame; even, ≥2; frame width = DWIDTH*NWORDS (default 256).
- FCNT_W, 16, width of delivered-frame counter.
- OVF_W, 8, width of saturating overflow counter.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- dv  in  1  sample valid, level; may stay high for several clk cycles per sample.
- dat_i  in  DWIDTH  signed sample; stable while dv is high.
- flush  in  1  synchronous; discards the partial frame.
- out_valid  out  1  frame available in out_data.
- out_ready  in  1  consumer accepts the frame when out_valid&&out_ready.
- out_data  out  DWIDTH*NWORDS  packed frame; sample k at [k*DWIDTH +: DWIDTH], LSB-first.
- half_pulse  out  1  one-cycle strobe at mid-frame.
- frame_cnt  out  FCNT_W  frames delivered to the output slot; wraps.
- ovf_cnt  out  OVF_W  frames dropped; saturates at all-ones.
- vad  in  1  present only with VAD_GATE_EN.

Behaviour:
- Reset (async, reset_n=0): dv_q=0, idx=0, fill buffer=0, out_data=0, out_valid=0, half_pulse=0, frame_cnt=0, ovf_cnt=0, output FSM=EMPTY. Outputs are all registered.
- Capture: on a clk edge where dv_q==0 && dv==1 (rising edge; dv_q is dv delayed one cycle), write dat_i into fill[idx] and increment idx. A dv held high counts as one sample.
- Half strobe: half_pulse=1 for exactly one cycle, in the cycle after the capture of sample index NWORDS/2-1.
- Commit: capture of sample index NWORDS-1 completes the frame and sets idx to 0.
  - If the slot is EMPTY, or FULL with out_ready=1 in that cycle: out_data takes the full frame including the final sample, out_valid=1, frame_cnt+1. Latency: out_valid is high in the cycle after the final capture edge.
  - If the slot is FULL and out_ready=0: the new frame is dropped, out_data is unchanged, ovf_cnt+1 (saturating).
- Output FSM:
  - EMPTY -> FULL on commit.
  - FULL -> EMPTY on out_valid&&out_ready without a simultaneous commit.
  - FULL -> FULL on a handshake with a simultaneous commit: out_valid stays 1 and out_data is replaced.
  - out_data holds its value after a handshake until the next commit.
- Flush: idx=0 and the partial frame is discarded. The fill buffer need not be cleared, but unfilled words of the next frame must never leak; every word is written before commit. Flush in the same cycle as a capture wins: the sample is discarded and no commit or half_pulse occurs. Flush does not affect the output slot or the counters.
- Handshake rule: out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Mid-operation reset clears everything immediately; no partial frame survives.

Optional Feature:
- Macro VAD_GATE_EN.
- Defined: vad port exists. Captures occur only while vad=1. A falling vad with idx≠0 acts as flush in that cycle, so partial utterance frames are discarded. The output slot is unaffected.
- Undefined: no vad port; every dv rising edge is captured.

Decomposition:
- Shared package rec_pkg holds:
  - default DWIDTH/NWORDS constants;
  - the output FSM encoding (SLOT_EMPTY=1'b0, SLOT_FULL=1'b1);
  - a log2 helper constant function for sizing idx.
- One natural sub-module: rise_edge_det, which registers dv and emits a one-cycle rise pulse. The packer reuses it for the vad falling detection, fed with ~vad.

Test Plan:
- Defaults; feed samples 0x0001..0x0010, each with dv held high 25 cycles, out_ready=1 -> one out_valid pulse; out_data[15:0]=0x0001, out_data[255:240]=0x0010; frame_cnt=1; half_pulse exactly once, after sample 8.
- out_ready=0, feed 3 full frames -> out_valid stays 1; out_data holds frame 1; frame_cnt=1; ovf_cnt=2. Then raise out_ready for 1 cycle -> out_valid=0.
- Hold out_ready=1 so the handshake coincides with commit of frame 2 -> out_valid stays high, out_data=frame 2, frame_cnt=2, ovf_cnt=0.
- Feed 5 samples, pulse flush coincident with the 6th dv rise, then feed 16 samples 0xA000+k -> out_data word 0 = 0xA000; no old data present.
- Assert reset_n=0 asynchronously mid-frame (idx=9) with the slot FULL -> out_valid, out_data, frame_cnt and ovf_cnt are all 0 immediately, without waiting for a clk edge.
- With VAD_GATE_EN: vad=1 for 10 samples then vad=0, then vad=1 for 16 samples -> exactly one frame, containing only the last 16 samples; ovf_cnt=0.
